// File: rtl/alu_share_arbiter_112.sv
// Purpose : shares one combinational ALU between two requesters with round-robin
//           arbitration and one id-tagged response channel.
// Latency : an op accepted in cycle N has rsp_valid high in cycle N+2; each op takes at least 3 cycles.
// Backpressure: a response is held stable until rsp_ready, and no new request is accepted meanwhile.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ctr      request handshake and operands, N = 0,1
//   rsp_valid/ready/id            response handshake and owner id
//   rsp_result/zero/overflow      ALU outputs latched at the end of the EXEC cycle
//   alu_a/alu_b/alu_ctr           registered operands to the external ALU
//   alu_result/zero/overflow      combinational ALU outputs
//   grant_cnt0/grant_cnt1         saturating count of accepted ops per requester
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
// Requester 1 can then starve. The default build uses round-robin.

module alu_share_arbiter_112 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_ctr,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_ctr,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,

    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_ctr,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      op_a_q,       op_a_d;
    logic [31:0]      op_b_q,       op_b_d;
    logic [2:0]       op_ctr_q,     op_ctr_d;
    logic             op_id_q,      op_id_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             rsp_ov_q,     rsp_ov_d;
    logic [CNT_W-1:0] cnt0_q,       cnt0_d;
    logic [CNT_W-1:0] cnt1_q,       cnt1_d;

    logic winner;
    logic accept;

    // Winner selection. It only matters when at least one requester is valid.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            // The requester that did not win last time gets the tie.
            winner = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign accept     = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == ST_IDLE) && req0_valid && !winner;
    assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  winner;

    // Next-state logic for the FSM and all of its registered outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctr_d     = op_ctr_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ov_d     = rsp_ov_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_a_d       = winner ? req1_a   : req0_a;
                    op_b_d       = winner ? req1_b   : req0_b;
                    op_ctr_d     = winner ? req1_ctr : req0_ctr;
                    op_id_d      = winner;
                    last_grant_d = winner;
                    if (winner) begin
                        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_ONE;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The operand registers have fed the ALU for the whole cycle. Its outputs are settled.
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_ov_d     = alu_overflow;
                rsp_id_d     = op_id_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // The return to IDLE costs one cycle. This forces a gap between responses.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctr_q     <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ov_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctr_q     <= op_ctr_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ov_q     <= rsp_ov_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // The operand registers keep the last op's values between ops.
    assign alu_a        = op_a_q;
    assign alu_b        = op_b_q;
    assign alu_ctr      = op_ctr_q;

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ov_q;

    assign grant_cnt0   = cnt0_q;
    assign grant_cnt1   = cnt1_q;

endmodule
